// File: rtl/pdp8ltty_fifo.sv
// pdp8ltty_fifo: PDP-8/L teletype IOT decoder with keyboard (ARM->CPU) and printer (CPU->ARM) FIFOs.
module pdp8ltty_fifo #(
  parameter logic [5:0] KBDEV = 6'o03,
  parameter int FIFOLOG2 = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        BINIT,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        iopstart,
  input  logic        iopstop,
  input  logic [11:0] ioopcode,
  input  logic [11:0] cputodev,
  output logic [11:0] devtocpu,
  output logic        AC_CLEAR,
  output logic        IO_SKIP,
  output logic        INT_RQST
);
  localparam int N = 2 ** FIFOLOG2;
  localparam int CW = FIFOLOG2 + 1;
  localparam logic [CW-1:0] DEPTH = CW'(N);
  localparam logic [5:0] TTDEV = KBDEV + 6'd1;
  logic [7:0] r_kbmem [N];
  logic [7:0] r_prmem [N];
  logic [FIFOLOG2-1:0] r_kbrp, r_kbwp, r_prrp, r_prwp;
  logic [CW-1:0] r_kbcnt, r_prcnt;
  logic r_enable, r_intenab, r_prflag, r_kbovf, r_provf, r_acclr, r_skip;
  logic [11:0] r_devtocpu;
  logic w_kbop, w_prop, w_kbempty, w_premp, w_kbflag, w_intrq;
  logic w_armkb, w_armpr, w_kbpop, w_kbpush, w_kbdrop, w_prpop, w_prpush, w_prdrop;
  logic [2:0] w_op;
  logic [7:0] w_kbhead, w_prhead;
  logic [CW-1:0] w_kbcnt_nx, w_prcnt_nx;
  logic w_unused;
  assign w_unused = &{1'b0, armwdata[28:8], cputodev[11:8]};
  assign w_op = ioopcode[2:0];
  assign w_kbop = iopstart & r_enable & (ioopcode[11:3] == {3'o6, KBDEV});
  assign w_prop = iopstart & r_enable & (ioopcode[11:3] == {3'o6, TTDEV});
  assign w_kbempty = r_kbcnt == '0;
  assign w_premp = r_prcnt == '0;
  assign w_kbflag = !w_kbempty;
  assign w_intrq = r_intenab & (w_kbflag | r_prflag);
  assign w_kbhead = w_kbempty ? 8'h00 : r_kbmem[r_kbrp];
  assign w_prhead = w_premp ? 8'h00 : r_prmem[r_prrp];
  assign w_armkb = armwrite & (armwaddr == 2'd1);
  assign w_armpr = armwrite & (armwaddr == 2'd2);
  // A pop in the same cycle frees a slot, so a push at full still lands
  assign w_kbpop = w_kbop & (w_op == 3'd2 || w_op == 3'd6) & !w_kbempty;
  assign w_kbpush = w_armkb & armwdata[31] & ((r_kbcnt != DEPTH) | w_kbpop);
  assign w_kbdrop = w_armkb & armwdata[31] & !w_kbpush;
  assign w_prpop = w_armpr & armwdata[31] & !w_premp;
  assign w_prpush = w_prop & (w_op == 3'd4 || w_op == 3'd6) & ((r_prcnt != DEPTH) | w_prpop);
  assign w_prdrop = w_prop & (w_op == 3'd4 || w_op == 3'd6) & !w_prpush;
  assign w_kbcnt_nx = r_kbcnt + CW'(w_kbpush) - CW'(w_kbpop);
  assign w_prcnt_nx = r_prcnt + CW'(w_prpush) - CW'(w_prpop);
  assign devtocpu = r_devtocpu;
  assign AC_CLEAR = r_acclr;
  assign IO_SKIP = r_skip;
  assign INT_RQST = w_intrq;
  always_comb
    armrdata = armraddr == 2'd0 ? 32'h54541006
             : armraddr == 2'd1 ? {w_kbflag, r_enable, r_kbovf, 6'b0, 7'(r_kbcnt), 8'b0, w_kbhead}
             : armraddr == 2'd2 ? {r_prflag, !w_premp, r_provf, 6'b0, 7'(r_prcnt), 8'b0, w_prhead}
             : {4'(FIFOLOG2), 22'b0, KBDEV};
  always_ff @(posedge CLOCK) begin
    if (w_kbpush) r_kbmem[r_kbwp] <= armwdata[7:0];
    if (w_prpush) r_prmem[r_prwp] <= cputodev[7:0];
  end
  always_ff @(posedge CLOCK) begin
    if (RESET | BINIT) begin
      if (RESET) r_enable <= 1'b0;
      r_kbrp <= '0;
      r_kbwp <= '0;
      r_prrp <= '0;
      r_prwp <= '0;
      r_kbcnt <= '0;
      r_prcnt <= '0;
      r_intenab <= 1'b0;
      r_prflag <= 1'b0;
      r_kbovf <= 1'b0;
      r_provf <= 1'b0;
      r_acclr <= 1'b0;
      r_skip <= 1'b0;
      r_devtocpu <= '0;
    end else begin
      if (w_armkb) r_enable <= armwdata[30];
      if (w_kbpush) r_kbwp <= r_kbwp + 1'b1;
      if (w_kbpop) r_kbrp <= r_kbrp + 1'b1;
      if (w_prpush) r_prwp <= r_prwp + 1'b1;
      if (w_prpop) r_prrp <= r_prrp + 1'b1;
      r_kbcnt <= w_kbcnt_nx;
      r_prcnt <= w_prcnt_nx;
      if (w_armkb & armwdata[29]) r_kbovf <= 1'b0;
      if (w_kbdrop) r_kbovf <= 1'b1;
      if (w_armpr & armwdata[29]) r_provf <= 1'b0;
      if (w_prdrop) r_provf <= 1'b1;
      if (w_prpop) r_prflag <= 1'b1;
      if (!r_enable | (iopstop & !iopstart)) begin
        r_acclr <= 1'b0;
        r_skip <= 1'b0;
        r_devtocpu <= '0;
      end
      if (w_kbop & (w_op == 3'd1)) r_skip <= w_kbflag;
      if (w_kbop & (w_op == 3'd2 || w_op == 3'd6)) r_acclr <= 1'b1;
      if (w_kbop & (w_op == 3'd4 || w_op == 3'd6)) r_devtocpu <= {4'b0, w_kbhead};
      if (w_kbop & (w_op == 3'd5)) r_intenab <= cputodev[0];
      if (w_prop & (w_op == 3'd1)) r_skip <= r_prflag;
      if (w_prop & (w_op == 3'd5)) r_skip <= w_intrq;
      if (w_prop & (w_op == 3'd6)) r_prflag <= w_prcnt_nx < DEPTH;
      // TCF comes last so it overrides a same-cycle ARM pop
      if (w_prop & (w_op == 3'd2)) r_prflag <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pdp8ltty_fifo.sv
// tb_pdp8ltty_fifo: directed scoreboard bench for the FIFO teletype block.
module tb_pdp8ltty_fifo;
  logic CLOCK = 1'b0, RESET, BINIT, armwrite, iopstart, iopstop;
  logic [1:0] armraddr, armwaddr;
  logic [31:0] armwdata, armrdata;
  logic [11:0] ioopcode, cputodev, devtocpu;
  logic AC_CLEAR, IO_SKIP, INT_RQST;
  int vectors = 0, miscompares = 0;
  logic [7:0] kbq[$], prq[$];
  logic m_en, m_kbovf, m_prflag, m_provf, m_intenab;
  localparam logic [11:0] KSF = 12'o6031, KRB = 12'o6036, KIE = 12'o6035;
  localparam logic [11:0] TSF = 12'o6041, TCF = 12'o6042, TPC = 12'o6044, TSK = 12'o6045, TLS = 12'o6046;

  pdp8ltty_fifo dut (
    .CLOCK(CLOCK), .RESET(RESET), .BINIT(BINIT), .armwrite(armwrite),
    .armraddr(armraddr), .armwaddr(armwaddr), .armwdata(armwdata), .armrdata(armrdata),
    .iopstart(iopstart), .iopstop(iopstop), .ioopcode(ioopcode), .cputodev(cputodev),
    .devtocpu(devtocpu), .AC_CLEAR(AC_CLEAR), .IO_SKIP(IO_SKIP), .INT_RQST(INT_RQST)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] e1();
    return {kbq.size() != 0, m_en, m_kbovf, 6'b0, 7'(kbq.size()), 8'b0, kbq.size() != 0 ? kbq[0] : 8'h00};
  endfunction

  function automatic logic [31:0] e2();
    return {m_prflag, prq.size() != 0, m_provf, 6'b0, 7'(prq.size()), 8'b0, prq.size() != 0 ? prq[0] : 8'h00};
  endfunction

  function automatic logic intr();
    return m_intenab & ((kbq.size() != 0) | m_prflag);
  endfunction

  task automatic tick;
    @(posedge CLOCK);
    #1;
    armwrite = 0; iopstart = 0; iopstop = 0; RESET = 0; BINIT = 0;
  endtask

  task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
    armraddr = a;
    #1;
    chk(tag, armrdata, exp);
  endtask

  task automatic armw(input logic [1:0] a, input logic [31:0] d);
    armwrite = 1; armwaddr = a; armwdata = d;
  endtask

  task automatic iop(input logic [11:0] op, input logic [11:0] ac);
    ioopcode = op; cputodev = ac; iopstart = 1;
  endtask

  task automatic stop;
    iopstop = 1;
    tick();
  endtask

  task automatic kbpush(input logic [7:0] c, input bit popping);
    armw(2'd1, {1'b1, m_en, 22'b0, c});
    if (kbq.size() < 16 || popping) kbq.push_back(c);
    else m_kbovf = 1;
  endtask

  task automatic krb(input string tag);
    logic [11:0] e;
    iop(KRB, 12'o0);
    tick();
    if (kbq.size() != 0) e = {4'b0, kbq.pop_front()};
    else e = 12'o0;
    chk(tag, devtocpu, e);
    chk({tag, "_acclr"}, AC_CLEAR, 1);
    stop();
    chk({tag, "_stop"}, devtocpu, 0);
  endtask

  task automatic prpush(input logic [11:0] op, input logic [7:0] c);
    iop(op, {4'b0, c});
    if (prq.size() < 16) prq.push_back(c);
    else m_provf = 1;
    if (op == TLS) m_prflag = prq.size() < 16;
  endtask

  task automatic prpop;
    armw(2'd2, 32'h80000000);
    if (prq.size() != 0) begin
      void'(prq.pop_front());
      m_prflag = 1;
    end
  endtask

  initial begin
    RESET = 1; BINIT = 0; armwrite = 0; armraddr = 0; armwaddr = 0; armwdata = 0;
    iopstart = 0; iopstop = 0; ioopcode = 0; cputodev = 0;
    m_en = 0; m_kbovf = 0; m_prflag = 0; m_provf = 0; m_intenab = 0;
    tick();
    rd(0, "id", 32'h54541006);
    rd(1, "r1_rst", e1());
    rd(2, "r2_rst", e2());
    rd(3, "r3", 32'h40000003);
    chk("dtc_rst", devtocpu, 0);
    chk("int_rst", INT_RQST, 0);
    // enable, then paste "ABC"
    m_en = 1;
    armw(2'd1, 32'h40000000);
    tick();
    for (int i = 0; i < 3; i++) begin
      kbpush(8'h41 + 8'(i), 0);
      tick();
    end
    rd(1, "r1_abc", e1());
    chk("r1_abc_lit", armrdata, 32'hC0030041);
    for (int i = 0; i < 3; i++) krb($sformatf("krb_abc%0d", i));
    rd(1, "r1_empty", e1());
    iop(KSF, 0); tick();
    chk("ksf_empty", IO_SKIP, 0);
    stop();
    kbpush(8'h31, 0); tick();
    iop(KSF, 0); tick();
    chk("ksf_full", IO_SKIP, 1);
    stop();
    chk("ksf_stop", IO_SKIP, 0);
    krb("krb_31");
    // keyboard overflow
    for (int i = 0; i < 17; i++) begin
      kbpush(8'h50 + 8'(i), 0);
      tick();
    end
    rd(1, "r1_ovf", e1());
    armw(2'd1, 32'h60000000); m_kbovf = 0; tick();
    rd(1, "r1_ovfclr", e1());
    for (int i = 0; i < 16; i++) krb($sformatf("krb_ovf%0d", i));
    rd(1, "r1_ovf_drained", e1());
    // printer fill with interrupts enabled
    iop(KIE, 12'o0001); m_intenab = 1; tick(); stop();
    chk("int_idle", INT_RQST, intr());
    for (int i = 0; i < 16; i++) begin
      prpush(TLS, 8'h48 + 8'(i));
      tick();
      rd(2, $sformatf("tls%0d", i), e2());
      chk($sformatf("tls_int%0d", i), INT_RQST, intr());
      stop();
    end
    prpush(TPC, 8'h7F); tick(); stop();
    rd(2, "tpc_ovf", e2());
    prpop(); tick();
    rd(2, "pr_pop1", e2());
    chk("int_pop1", INT_RQST, intr());
    iop(TSF, 0); tick();
    chk("tsf", IO_SKIP, m_prflag);
    stop();
    iop(TSK, 0); tick();
    chk("tsk", IO_SKIP, intr());
    stop();
    armw(2'd2, 32'h20000000); m_provf = 0; tick();
    rd(2, "provf_clr", e2());
    prpop(); iop(TCF, 0); m_prflag = 0; tick(); stop();
    rd(2, "tcf_and_pop", e2());
    while (prq.size() != 0) begin
      rd(2, "pr_drain", e2());
      prpop(); tick();
    end
    rd(2, "pr_drained", e2());
    iop(TCF, 0); m_prflag = 0; tick(); stop();
    chk("int_tcf", INT_RQST, intr());
    // same-cycle push and pop
    kbpush(8'h58, 0); tick();
    kbpush(8'h59, 1);
    krb("same1");
    rd(1, "same1_r1", e1());
    for (int i = 0; i < 15; i++) begin
      kbpush(8'h60 + 8'(i), 0);
      tick();
    end
    rd(1, "full_r1", e1());
    kbpush(8'h7A, 1);
    krb("samefull");
    rd(1, "samefull_r1", e1());
    for (int i = 0; i < 16; i++) krb($sformatf("krb_same%0d", i));
    // BINIT keeps enable only
    for (int i = 0; i < 3; i++) begin
      kbpush(8'h21 + 8'(i), 0);
      tick();
    end
    prpush(TPC, 8'h11); tick(); stop();
    prpush(TPC, 8'h12); tick(); stop();
    BINIT = 1; tick();
    kbq.delete(); prq.delete();
    m_kbovf = 0; m_provf = 0; m_prflag = 0; m_intenab = 0;
    rd(1, "binit_r1", e1());
    rd(2, "binit_r2", e2());
    kbpush(8'h22, 0); tick();
    chk("binit_intenab", INT_RQST, intr());
    // RESET clears enable; IOPs then ignored
    RESET = 1; tick();
    kbq.delete(); m_en = 0;
    rd(1, "rst_r1", e1());
    kbpush(8'h33, 0); tick();
    rd(1, "dis_push", e1());
    iop(KSF, 0); tick();
    chk("dis_ksf", IO_SKIP, 0);
    stop();
    iop(KRB, 0); tick();
    chk("dis_krb", devtocpu, 0);
    chk("dis_acclr", AC_CLEAR, 0);
    stop();
    rd(1, "dis_r1", e1());
    // pointer wrap
    m_en = 1;
    armw(2'd1, 32'h40000000); tick();
    krb("wrap_pre");
    for (int i = 0; i < 40; i++) begin
      kbpush(8'(i * 7 + 1), 0);
      tick();
      krb($sformatf("wrap%0d", i));
    end
    rd(1, "wrap_end", e1());
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
